seg7_char_reader: RTL and testbench
===================================

Name: seg7_char_reader

Overview:
- Reads back 7-segment patterns of the 4-character alphabet d/E/1/blank and recovers the 2-bit character codes the display path encoded.
- Sits between a segment-pattern source (display scanner or self-check tap on HEX2..HEX0) and a consumer (LEDR/status logic).
- Assembles three characters into one frame, checks rotation consistency across the frame, then offers the frame on a valid/ready handshake.

Parameters:
- ACTIVE_LOW, 1: 1 = segment bit 0 means lit (DE-series HEX); 0 = 1 means lit.
- CHECK_ROT, 1: 1 = enable rotation check; 0 = rot_err always 0.
- CNT_W, 8: width of the saturating error-frame counter.

Ports:
- Clock  in  1  Single clock; all state on rising edge.
- Reset  in  1  Asynchronous, active-high reset.
- seg_in  in  7  Segment pattern; bit0=a … bit6=g.
- seg_valid  in  1  seg_in carries a character this cycle.
- seg_first  in  1  Qualified by seg_valid; character is first (HEX2) of a frame.
- seg_ready  out  1  Block accepts a character this cycle.
- out_valid  out  1  Frame available.
- out_ready  in  1  Consumer accepts frame.
- out_word  out  6  {char0, char1, char2}; char0 in [5:4].
- char_err  out  1  Frame contained an unrecognised pattern.
- rot_err  out  1  Frame violated the rotation rule.
- err_count  out  CNT_W  Saturating count of frames with char_err or rot_err.

Behaviour:
- Decode, after normalising to active-low. Only exact matches are legal:
  - 7'b0100001 → 00 (d)
  - 7'b0000110 → 01 (E)
  - 7'b1111001 → 10 (1)
  - 7'b1111111 → 11 (blank)
  - Any other pattern → code 11 with the frame's char_err flag set.
- Rotation rule: next = {~c1&c0, ~c1&~c0}, i.e. d→E→1→d and blank→d.
  - Frame is consistent when char1 = next(char0) and char2 = next(char1).
  - Check uses decoded codes, including the substituted 11.
- Accept: a character is accepted when seg_valid && seg_ready.
- FSM states: WAIT0, WAIT1, WAIT2, HOLD. Reset state is WAIT0.
  - WAIT0: seg_ready=1. Accepted char with seg_first=1 → store char0, go WAIT1. Accepted char with seg_first=0 → discard (resync), stay.
  - WAIT1: seg_ready=1. Accepted char with seg_first=1 → restart: store as char0, clear flags, stay WAIT1. Otherwise store char1, go WAIT2.
  - WAIT2: seg_ready=1. Accepted char with seg_first=1 → restart as in WAIT1, go WAIT1. Otherwise store char2; next cycle out_valid=1, out_word/flags registered, go HOLD.
  - HOLD: seg_ready=0 (backpressure). out_word, char_err, rot_err held stable while out_valid && !out_ready. When out_valid && out_ready → out_valid=0, go WAIT0.
- Latency: out_valid asserts 1 cycle after the 3rd character is accepted.
- No bypass from HOLD to WAIT1: the next frame's first char is taken at earliest the cycle after the handshake.
- char_err accumulates per frame; it clears on frame start (char0 accepted) and on restart.
- err_count:
  - Increments by 1 in the cycle out_valid rises, if char_err|rot_err for that frame.
  - Saturates at all-ones; never wraps.
  - Cleared only by Reset.
- Reset (asserted anytime, including mid-frame or in HOLD), immediately:
  - state=WAIT0, seg_ready=1 after release, out_valid=0.
  - out_word=0, char_err=0, rot_err=0, err_count=0.
  - Partial frame is discarded.
- seg_first is ignored when seg_valid=0. seg_in is ignored when not accepted.

Test Plan:
- Clean frame, ACTIVE_LOW=1: d(0100001,first), E(0000110), 1(1111001), out_ready=1 → out_valid 1 cycle after 3rd char; out_word=6'b000110, char_err=0, rot_err=0, err_count=0.
- Rotation violation: E,E,1 → out_word=6'b010110, rot_err=1, err_count=1. Same with CHECK_ROT=0 → rot_err=0, err_count=0.
- Illegal pattern: d, 7'b0000000, E → char_err=1, out_word=6'b001101, rot_err=1 (11→00 expected, 01 seen), err_count increments.
- Backpressure: valid frame, out_ready=0 for 5 cycles → out_valid and out_word stable, seg_ready=0, new seg_valid ignored. Raise out_ready → handshake, WAIT0 next cycle.
- Resync/restart: seg_valid with seg_first=0 in WAIT0 → discarded. Two chars, then seg_first=1 → frame restarts; output reflects only the new 3 chars.
- Reset mid-frame and in HOLD → all outputs 0 asynchronously. Next clean frame decodes correctly. CNT_W=2 with 5 bad frames → err_count stays 2'b11.

Source files
------------

// File: rtl/seg7_char_reader.sv
// rtl/seg7_char_reader.sv - recovers 2-bit d/E/1/blank codes from 7-segment patterns
// and emits three-character frames with char/rotation error flags.
module seg7_char_reader #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit CHECK_ROT  = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_seg_in,
  input  logic             i_seg_valid,
  input  logic             i_seg_first,
  output logic             o_seg_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [5:0]       o_out_word,
  output logic             o_char_err,
  output logic             o_rot_err,
  output logic [CNT_W-1:0] o_err_count
);

  typedef enum logic [1:0] {WAIT0, WAIT1, WAIT2, HOLD} state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_c0, r_c1;
  logic             r_cerr;
  logic [5:0]       r_word;
  logic             r_char_err, r_rot_err;
  logic [CNT_W-1:0] r_cnt;

  logic [6:0] w_seg_n;
  logic [1:0] w_code;
  logic       w_illegal, w_accept, w_done, w_rot_bad, w_frame_err;

  function automatic logic [1:0] rot_next(input logic [1:0] c);
    return {~c[1] & c[0], ~c[1] & ~c[0]};
  endfunction

  assign w_seg_n = ACTIVE_LOW ? i_seg_in : ~i_seg_in;

  // Unknown patterns still yield code 11 so the rotation check sees a defined value.
  always_comb begin
    w_code    = 2'b11;
    w_illegal = 1'b0;
    case (w_seg_n)
      7'b0100001: w_code = 2'b00;
      7'b0000110: w_code = 2'b01;
      7'b1111001: w_code = 2'b10;
      7'b1111111: w_code = 2'b11;
      default:    w_illegal = 1'b1;
    endcase
  end

  assign w_accept    = i_seg_valid && o_seg_ready;
  assign w_done      = (r_state == WAIT2) && w_accept && !i_seg_first;
  assign w_rot_bad   = CHECK_ROT &&
                       ((r_c1 != rot_next(r_c0)) || (w_code != rot_next(r_c1)));
  assign w_frame_err = r_cerr | w_illegal | w_rot_bad;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= WAIT0;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_seg_ready = 1'b1;
    o_out_valid = 1'b0;
    case (r_state)
      WAIT0: if (w_accept && i_seg_first) w_next = WAIT1;
      WAIT1: if (w_accept) w_next = i_seg_first ? WAIT1 : WAIT2;
      WAIT2: if (w_accept) w_next = i_seg_first ? WAIT1 : HOLD;
      HOLD: begin
        o_seg_ready = 1'b0;
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = WAIT0;
      end
      default: w_next = WAIT0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c0       <= 2'b00;
      r_c1       <= 2'b00;
      r_cerr     <= 1'b0;
      r_word     <= 6'b0;
      r_char_err <= 1'b0;
      r_rot_err  <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept && i_seg_first) begin
      r_c0   <= w_code;
      r_cerr <= w_illegal;
    end else if (w_accept && r_state == WAIT1) begin
      r_c1   <= w_code;
      r_cerr <= r_cerr | w_illegal;
    end else if (w_done) begin
      r_word     <= {r_c0, r_c1, w_code};
      r_char_err <= r_cerr | w_illegal;
      r_rot_err  <= w_rot_bad;
      if (w_frame_err && r_cnt != '1)
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_out_word  = r_word;
  assign o_char_err  = r_char_err;
  assign o_rot_err   = r_rot_err;
  assign o_err_count = r_cnt;

endmodule

// File: tb/tb_seg7_char_reader.sv
// tb/tb_seg7_char_reader.sv - scoreboard bench for seg7_char_reader
// (default, no-rotation-check, and active-high/2-bit-counter instances in lockstep).
module tb_seg7_char_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [6:0] seg_in, seg_inv;
  logic       seg_valid, seg_first, out_ready;
  assign seg_inv = ~seg_in;

  logic       ready_a, valid_a, cerr_a, rerr_a;
  logic [5:0] word_a;
  logic [7:0] cnt_a;
  logic       ready_n, valid_n, cerr_n, rerr_n;
  logic [5:0] word_n;
  logic [7:0] cnt_n;
  logic       ready_c, valid_c, cerr_c, rerr_c;
  logic [5:0] word_c;
  logic [1:0] cnt_c;

  seg7_char_reader dut (
    .i_clk(clk), .i_rst(rst), .i_seg_in(seg_in), .i_seg_valid(seg_valid),
    .i_seg_first(seg_first), .o_seg_ready(ready_a), .o_out_valid(valid_a),
    .i_out_ready(out_ready), .o_out_word(word_a), .o_char_err(cerr_a),
    .o_rot_err(rerr_a), .o_err_count(cnt_a));

  seg7_char_reader #(.CHECK_ROT(1'b0)) dut_nr (
    .i_clk(clk), .i_rst(rst), .i_seg_in(seg_in), .i_seg_valid(seg_valid),
    .i_seg_first(seg_first), .o_seg_ready(ready_n), .o_out_valid(valid_n),
    .i_out_ready(out_ready), .o_out_word(word_n), .o_char_err(cerr_n),
    .o_rot_err(rerr_n), .o_err_count(cnt_n));

  seg7_char_reader #(.ACTIVE_LOW(1'b0), .CNT_W(2)) dut_c2 (
    .i_clk(clk), .i_rst(rst), .i_seg_in(seg_inv), .i_seg_valid(seg_valid),
    .i_seg_first(seg_first), .o_seg_ready(ready_c), .o_out_valid(valid_c),
    .i_out_ready(out_ready), .o_out_word(word_c), .o_char_err(cerr_c),
    .o_rot_err(rerr_c), .o_err_count(cnt_c));

  localparam logic [6:0] P_D = 7'b0100001;
  localparam logic [6:0] P_E = 7'b0000110;
  localparam logic [6:0] P_1 = 7'b1111001;
  localparam logic [6:0] P_B = 7'b1111111;
  localparam logic [6:0] P_X = 7'b0000000;

  typedef struct packed {
    logic [5:0] word;
    logic       cerr;
    logic       rerr;
    logic [7:0] cnt;
    logic [7:0] cnt_nr;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   fails  = 0;
  int   m_cnt = 0, m_cnt_nr = 0, m_cnt2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: one pop per handshake cycle.
  always @(negedge clk) begin
    if (!rst && valid_a && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_frame actual=%0h required=none", word_a);
      end else begin
        m_e = sb.pop_front();
        chk("word",       word_a,  m_e.word);
        chk("char_err",   cerr_a,  m_e.cerr);
        chk("rot_err",    rerr_a,  m_e.rerr);
        chk("err_count",  cnt_a,   m_e.cnt);
        chk("nr_valid",   valid_n, 1);
        chk("nr_word",    word_n,  m_e.word);
        chk("nr_rot_err", rerr_n,  0);
        chk("nr_count",   cnt_n,   m_e.cnt_nr);
        chk("c2_valid",   valid_c, 1);
        chk("c2_word",    word_c,  m_e.word);
        chk("c2_cerr",    cerr_c,  m_e.cerr);
        chk("c2_rot_err", rerr_c,  m_e.rerr);
        chk("c2_count",   cnt_c,   m_e.cnt2);
      end
    end
  end

  task automatic push_exp(input logic [5:0] word, input logic cerr, input logic rerr);
    exp_t e;
    if (cerr | rerr) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3)  m_cnt2++;
    end
    if (cerr) m_cnt_nr++;
    e.word = word; e.cerr = cerr; e.rerr = rerr;
    e.cnt = 8'(m_cnt); e.cnt_nr = 8'(m_cnt_nr); e.cnt2 = 2'(m_cnt2);
    sb.push_back(e);
  endtask

  // Caller is always 1 time unit past a rising edge.
  task automatic send_char(input logic [6:0] p, input logic f);
    logic r;
    bit   ok;
    ok = 1'b0;
    seg_in = p; seg_first = f; seg_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r = ready_a;
      @(posedge clk);
      #1;
      if (r) begin ok = 1'b1; break; end
    end
    seg_valid = 1'b0; seg_first = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic finish_frame();
    chk("latency_valid", valid_a, 1);
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                            input logic [5:0] word, input logic cerr, input logic rerr,
                            input bit push);
    if (push) push_exp(word, cerr, rerr);
    send_char(p0, 1'b1);
    send_char(p1, 1'b0);
    send_char(p2, 1'b0);
    finish_frame();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, valid_a, 0);
    chk({tag, "_word"},  word_a,  0);
    chk({tag, "_cerr"},  cerr_a,  0);
    chk({tag, "_rerr"},  rerr_a,  0);
    chk({tag, "_cnt"},   cnt_a,   0);
    chk({tag, "_cnt2"},  cnt_c,   0);
  endtask

  initial begin
    rst = 1'b1; seg_in = 7'b0; seg_valid = 1'b0; seg_first = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", ready_a, 1);

    send_frame(P_D, P_E, P_1, 6'b000110, 1'b0, 1'b0, 1);
    send_frame(P_E, P_E, P_1, 6'b010110, 1'b0, 1'b1, 1);
    send_frame(P_D, P_X, P_E, 6'b001101, 1'b1, 1'b1, 1);
    send_frame(P_1, P_D, P_E, 6'b100001, 1'b0, 1'b0, 1);
    send_frame(P_B, P_D, P_E, 6'b110001, 1'b0, 1'b0, 1);

    out_ready = 1'b0;
    send_frame(P_D, P_E, P_1, 6'b000110, 1'b0, 1'b0, 1);
    seg_in = P_E; seg_first = 1'b1; seg_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", valid_a, 1);
      chk("bp_word",  word_a,  6'b000110);
      chk("bp_ready", ready_a, 0);
    end
    seg_valid = 1'b0; seg_first = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_valid", valid_a, 0);
    chk("hs_ready", ready_a, 1);

    push_exp(6'b011000, 1'b0, 1'b0);
    send_char(P_D, 1'b0);
    send_char(P_D, 1'b1);
    send_char(P_E, 1'b0);
    send_char(P_E, 1'b1);
    send_char(P_1, 1'b0);
    send_char(P_D, 1'b0);
    finish_frame();

    push_exp(6'b100001, 1'b0, 1'b0);
    send_char(P_D, 1'b1);
    send_char(P_1, 1'b1);
    send_char(P_D, 1'b0);
    send_char(P_E, 1'b0);
    finish_frame();

    send_char(P_D, 1'b1);
    send_char(P_E, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero("midframe");
    #2 rst = 1'b0;
    m_cnt = 0; m_cnt_nr = 0; m_cnt2 = 0;
    @(posedge clk);
    #1;
    send_frame(P_D, P_E, P_1, 6'b000110, 1'b0, 1'b0, 1);

    out_ready = 1'b0;
    send_frame(P_E, P_E, P_1, 6'b010110, 1'b0, 1'b1, 0);
    #2 rst = 1'b1;
    #1 check_zero("hold");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("post_hold_ready", ready_a, 1);

    repeat (5) send_frame(P_E, P_E, P_1, 6'b010110, 1'b0, 1'b1, 1);
    send_frame(P_D, P_X, P_E, 6'b001101, 1'b1, 1'b1, 1);
    send_frame(P_D, P_E, P_1, 6'b000110, 1'b0, 1'b0, 1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
